tile_frame_writer: RTL
======================

Name: tile_frame_writer

Overview:
Write-side producer for the double-buffered 32x24 tile frame buffer (20x20-pixel tiles, 640x480 display).
- Each frame it clears the back buffer to a background colour, then paints queued rectangle commands into it.
- It drives the frame-buffer write port (addrWrite/dataWrite) every cycle, because that port has no write enable and writes continuously into whichever buffer is not being displayed.
- Command source is game/UI logic through a valid/ready queue.

Parameters:
COLS, 32, tiles per row; address = row*COLS + col
ROWS, 24, tile rows; NUM_TILES = COLS*ROWS = 768
FIFO_DEPTH, 4, command queue entries (power of 2)
BG_COLOR, 8'h00, colour written during clear

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse, coincident with buffer swap (h==0 && v==0)
cmd_valid  in  1  rectangle command offered
cmd_ready  out  1  queue not full; command accepted when valid && ready
cmd_x  in  5  left tile column
cmd_y  in  5  top tile row
cmd_w  in  6  width in tiles (0..32)
cmd_h  in  5  height in tiles (0..24)
cmd_color  in  8  fill colour
addrWrite  out  10  frame-buffer write address (registered)
dataWrite  out  8  frame-buffer write data (registered)
busy  out  1  high in CLEAR or DRAW
frame_done  out  1  one-cycle pulse on entering DONE
overrun  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, addrWrite=0, dataWrite=BG_COLOR, cmd_ready=0, busy=0, frame_done=0, overrun=0. After release, cmd_ready = !fifo_full.
- States: IDLE, CLEAR, FETCH, DRAW, DONE.
- IDLE/DONE: hold addrWrite/dataWrite at their last values. The resulting repeated write is harmless. Wait for frame_start.
- frame_start in any state: go to CLEAR at cycle t; addrWrite=0, dataWrite=BG_COLOR at t+1.
- CLEAR: one write per cycle, addresses 0..767 ascending; address 767 appears at t+768. Then go to FETCH.
- FETCH:
  - If the FIFO is empty, go to DONE and pulse frame_done.
  - Otherwise pop one command (1 cycle, no new write) and compute the clipped rectangle:
    - col_end = min(x+w, COLS)
    - row_end = min(y+h, ROWS)
  - If w==0, h==0, x>=COLS or y>=ROWS, discard the command and stay in FETCH next cycle. Otherwise go to DRAW.
- DRAW: raster order, row-major, one tile per cycle. addrWrite = row*COLS+col (10-bit, no wrap), dataWrite = colour. After (row_end-1, col_end-1) return to FETCH.
- Latency: first write of first command appears 2 cycles after the last CLEAR write. Each command costs 1 + clipped_w*clipped_h cycles.
- Later commands overwrite earlier ones (painter's order).
- Commands are consumed. The producer resubmits every frame.
- frame_start while busy:
  - Pulse overrun, drop the in-flight command, restart CLEAR at address 0.
  - The FIFO is not flushed.
- Push and pop on the same cycle are both honoured. cmd_ready is based on registered full, so no push happens when full.
- Reset mid-operation: immediate return to the reset values; queued commands are lost.

Decomposition:
- Package vga_tile_pkg:
  - Constants: COLS, ROWS, TILE_PX=20, NUM_TILES.
  - Typedefs: tile_addr_t [9:0], color_t [7:0].
  - rect_cmd_t struct {x, y, w, h, color} (29 bits).
  - writer_state_t enum.
- Sub-module cmd_fifo: synchronous FIFO, width 29, depth FIFO_DEPTH, async active-low reset, full/empty flags.

Test Plan:
- Reset, then frame_start with no commands -> addrWrite 0..767 on consecutive cycles with dataWrite 8'h00; frame_done pulses at t+769; outputs then hold at 767/00.
- Queue {x=2,y=3,w=2,h=2,color=8'hE0} before frame_start -> after clear, writes 98,99,130,131 with E0, then frame_done.
- Queue {x=30,y=22,w=5,h=5,color=8'h1C} -> clipped writes 734,735,766,767 only.
- Queue w=0 command then {x=0,y=0,w=1,h=1,color=8'h03} -> first command produces no writes; address 0 written with 03.
- Push 5 commands with FIFO_DEPTH=4 and no pops -> cmd_ready drops after the 4th; the 5th is held until a pop frees a slot.
- Queue a large rectangle, then pulse frame_start during DRAW -> overrun pulses, next write is address 0 with BG_COLOR, and the remaining FIFO entries are drawn after the clear.

Source files
------------

// File: rtl/vga_tile_pkg.sv
// Shared types and geometry for the 32x24 tile frame buffer write path.
package vga_tile_pkg;
  localparam int COLS      = 32;
  localparam int ROWS      = 24;
  localparam int TILE_PX   = 20;
  localparam int NUM_TILES = COLS * ROWS;

  typedef logic [9:0] tile_addr_t;
  typedef logic [7:0] color_t;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [5:0] w;
    logic [4:0] h;
    color_t     color;
  } rect_cmd_t;

  localparam int CMD_W = $bits(rect_cmd_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAW,
    ST_DONE
  } writer_state_t;
endpackage

// File: rtl/cmd_fifo.sv
// Small first-word-fall-through command queue with registered full/empty.
module cmd_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/tile_frame_writer.sv
// Clears the back tile buffer each frame, then paints queued rectangles in
// raster order onto the always-writing frame-buffer port.
module tile_frame_writer
  import vga_tile_pkg::*;
#(
  parameter int     FIFO_DEPTH = 4,
  parameter color_t BG_COLOR   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_x,
  input  logic [4:0] cmd_y,
  input  logic [5:0] cmd_w,
  input  logic [4:0] cmd_h,
  input  logic [7:0] cmd_color,
  output logic [9:0] addrWrite,
  output logic [7:0] dataWrite,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);
  writer_state_t r_state, w_state_next;
  tile_addr_t    r_addr, r_clr_addr, w_draw_addr;
  color_t        r_data, r_color;
  logic [5:0]    r_col, r_col_end, w_col_end;
  logic [4:0]    r_col_start, r_row, r_row_end, w_row_end;
  logic [6:0]    w_x_end;
  logic [5:0]    w_y_end;
  logic          r_frame_done, r_overrun, r_ready_en;
  logic          w_full, w_empty, w_pop, w_discard;
  logic          w_col_last, w_row_last;
  rect_cmd_t     w_in_cmd, w_head;

  assign w_in_cmd = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .wdata (w_in_cmd),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign cmd_ready  = r_ready_en && !w_full;
  assign busy       = (r_state == ST_CLEAR) || (r_state == ST_DRAW);
  assign addrWrite  = r_addr;
  assign dataWrite  = r_data;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

  // Clip the head command against the tile grid.
  assign w_x_end   = {2'b00, w_head.x} + {1'b0, w_head.w};
  assign w_y_end   = {1'b0, w_head.y} + {1'b0, w_head.h};
  assign w_col_end = (w_x_end > 7'(COLS)) ? 6'(COLS) : w_x_end[5:0];
  assign w_row_end = (w_y_end > 6'(ROWS)) ? 5'(ROWS) : w_y_end[4:0];
  assign w_discard = (w_head.w == '0) || (w_head.h == '0) ||
                     ({1'b0, w_head.x} >= 6'(COLS)) || (w_head.y >= 5'(ROWS));

  assign w_col_last  = (r_col + 6'd1 == r_col_end);
  assign w_row_last  = (r_row + 5'd1 == r_row_end);
  assign w_draw_addr = tile_addr_t'(r_row) * tile_addr_t'(COLS) + tile_addr_t'(r_col);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    if (frame_start) begin
      w_state_next = ST_CLEAR;
    end else begin
      case (r_state)
        ST_CLEAR: if (r_clr_addr == tile_addr_t'(NUM_TILES - 1)) w_state_next = ST_FETCH;
        ST_FETCH: begin
          if (w_empty) begin
            w_state_next = ST_DONE;
          end else begin
            w_pop = 1'b1;
            if (!w_discard) w_state_next = ST_DRAW;
          end
        end
        ST_DRAW:  if (w_col_last && w_row_last) w_state_next = ST_FETCH;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // A frame_start cycle issues no write, which drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_data       <= BG_COLOR;
      r_clr_addr   <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_col_start  <= '0;
      r_col_end    <= '0;
      r_row_end    <= '0;
      r_color      <= BG_COLOR;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_ready_en   <= 1'b0;
    end else begin
      r_ready_en   <= 1'b1;
      r_frame_done <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
      r_overrun    <= frame_start && busy;
      if (frame_start) begin
        r_clr_addr <= '0;
      end else begin
        case (r_state)
          ST_CLEAR: begin
            r_addr     <= r_clr_addr;
            r_data     <= BG_COLOR;
            r_clr_addr <= r_clr_addr + 1'b1;
          end
          ST_FETCH: begin
            if (w_pop) begin
              r_col       <= {1'b0, w_head.x};
              r_col_start <= w_head.x;
              r_row       <= w_head.y;
              r_col_end   <= w_col_end;
              r_row_end   <= w_row_end;
              r_color     <= w_head.color;
            end
          end
          ST_DRAW: begin
            r_addr <= w_draw_addr;
            r_data <= r_color;
            if (w_col_last) begin
              r_col <= {1'b0, r_col_start};
              r_row <= r_row + 5'd1;
            end else begin
              r_col <= r_col + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
